pipe_inverse_div: RTL and testbench

//  Inverse of the 3-stage arithmetic pipeline F = D*((A+B)+(C-D)).

---
 rtl/pipe_inverse_div.sv | 132 +++++++++++++
 tb/tb_pipe_inverse_div.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_inverse_div.sv
`default_nettype none
// ============================================================================
// Module   : pipe_inverse_div
// Brief    : Inverts F = D*((A+B)+(C-D)). Restoring divider gives x3 = F/D, ab = x3 + D - C.
//            Define INV_REM_EN to export the remainder on port rem.
// Revision : 1.0  initial release
// ============================================================================
module pipe_inverse_div #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  input  logic [N-1:0] C,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] x3,
  output logic [N-1:0] ab,
  output logic         dz
`ifdef INV_REM_EN
  ,
  output logic [N-1:0] rem
`endif
);

  localparam int c_CNT_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [N-1:0]       r_fq;
  logic [N:0]         r_prem;
  logic [N-1:0]       r_d;
  logic [N-1:0]       r_c;
  logic               r_out_valid;
  logic [N-1:0]       r_x3;
  logic [N-1:0]       r_ab;
  logic               r_dz;
  logic [N-1:0]       r_rem;

  logic [N+1:0]       w_shift;
  logic [N+1:0]       w_sub;
  logic               w_ge;
  logic [N:0]         w_prem_nxt;
  logic [N-1:0]       w_fq_nxt;
  logic [N-1:0]       w_ab_nxt;

  // r_fq shifts dividend bits out of the top while quotient bits enter at the bottom
  assign w_shift    = {r_prem, r_fq[N-1]};
  assign w_sub      = w_shift - {2'b00, r_d};
  assign w_ge       = ~w_sub[N+1];
  assign w_prem_nxt = w_ge ? w_sub[N:0] : w_shift[N:0];
  assign w_fq_nxt   = {r_fq[N-2:0], w_ge};
  assign w_ab_nxt   = w_fq_nxt + r_d - r_c;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign x3        = r_x3;
  assign ab        = r_ab;
  assign dz        = r_dz;
`ifdef INV_REM_EN
  assign rem       = r_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fq        <= '0;
      r_prem      <= '0;
      r_d         <= '0;
      r_c         <= '0;
      r_out_valid <= 1'b0;
      r_x3        <= '0;
      r_ab        <= '0;
      r_dz        <= 1'b0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_fq   <= F;
            r_d    <= D;
            r_c    <= C;
            r_prem <= '0;
            if (D != '0) begin
              r_cnt   <= c_CNT_W'(N - 1);
              r_state <= S_DIV;
            end else begin
              r_x3        <= {N{1'b1}};
              r_ab        <= {N{1'b1}} - C;
              r_dz        <= 1'b1;
              r_rem       <= F;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DIV: begin
          r_fq   <= w_fq_nxt;
          r_prem <= w_prem_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_x3        <= w_fq_nxt;
            r_ab        <= w_ab_nxt;
            r_dz        <= 1'b0;
            r_rem       <= w_prem_nxt[N-1:0];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_inverse_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_inverse_div
// Brief    : Self-checking bench for pipe_inverse_div against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_inverse_div;

  localparam int N    = 10;
  localparam int MASK = (1 << N) - 1;
`ifdef INV_REM_EN
  localparam bit HAS_REM = 1'b1;
`else
  localparam bit HAS_REM = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] x3;
    logic [N-1:0] ab;
    logic [N-1:0] rem;
    logic         dz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] F = '0;
  logic [N-1:0] D = '0;
  logic [N-1:0] C = '0;
  logic         in_ready;
  logic         out_valid;
  logic         dz;
  logic [N-1:0] x3;
  logic [N-1:0] ab;
  logic [N-1:0] rem_obs;
  res_t         obs;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_inverse_div #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .F         (F),
    .D         (D),
    .C         (C),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x3        (x3),
    .ab        (ab),
    .dz        (dz)
`ifdef INV_REM_EN
    ,
    .rem       (rem_obs)
`endif
  );

`ifndef INV_REM_EN
  assign rem_obs = '0;
`endif
  assign obs = {x3, ab, rem_obs, dz};

  always #5 clk = ~clk;

  // Plain integer division; the remainder field is zero when the port is not built
  function automatic res_t model(input logic [N-1:0] f, input logic [N-1:0] d, input logic [N-1:0] c);
    res_t r;
    int   q;
    int   s;
    if (d == '0) begin
      q     = MASK;
      r.rem = f;
      r.dz  = 1'b1;
    end else begin
      q     = int'(f) / int'(d);
      s     = int'(f) % int'(d);
      r.rem = s[N-1:0];
      r.dz  = 1'b0;
    end
    r.x3 = q[N-1:0];
    s    = (q + int'(d) - int'(c)) & MASK;
    r.ab = s[N-1:0];
    if (!HAS_REM) r.rem = '0;
    return r;
  endfunction

  // Called #1 after an edge with the DUT idle; lat counts edges until out_valid is seen
  task automatic run_op(input logic [N-1:0] f, input logic [N-1:0] d, input logic [N-1:0] c,
                        output int lat);
    F = f; D = d; C = c; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 4 * N) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, {(3*N+1){1'b0}}}) begin
      tests_failed++;
      $display("FAIL reset_state: got out_valid=%0b in_ready=%0b res=%h expected 0 1 0",
               out_valid, in_ready, obs);
    end
    F = 10'd50; D = '0; C = 10'd5; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_no_capture: got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    res_t e;
    int   lat;
    e = model(10'd156, 10'd6, 10'd20);
    run_op(10'd156, 10'd6, 10'd20, lat);
    tests_run++;
    if (lat !== N + 1) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected %0d", lat, N + 1);
    end
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL basic_result: got x3=%0d ab=%0d rem=%0d dz=%0d expected x3=%0d ab=%0d rem=%0d dz=%0d",
               obs.x3, obs.ab, obs.rem, obs.dz, e.x3, e.ab, e.rem, e.dz);
    end
    handshake();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_release: got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_remainder_wrap();
    logic [N-1:0] tf [3];
    logic [N-1:0] td [3];
    logic [N-1:0] tc [3];
    res_t         e;
    int           lat;
    tf[0] = 10'd1023; td[0] = 10'd1;    tc[0] = 10'd0;
    tf[1] = 10'd100;  td[1] = 10'd7;    tc[1] = 10'd3;
    tf[2] = 10'd5;    td[2] = 10'd1023; tc[2] = 10'd1000;
    for (int i = 0; i < 3; i++) begin
      e = model(tf[i], td[i], tc[i]);
      run_op(tf[i], td[i], tc[i], lat);
      tests_run++;
      if (lat !== N + 1 || obs !== e) begin
        tests_failed++;
        $display("FAIL remwrap_%0d: got lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d expected lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d",
                 i, lat, obs.x3, obs.ab, obs.rem, obs.dz, N + 1, e.x3, e.ab, e.rem, e.dz);
      end
      handshake();
    end
  endtask

  task automatic test_div_zero();
    res_t e;
    int   lat;
    e = model(10'd50, 10'd0, 10'd5);
    run_op(10'd50, 10'd0, 10'd5, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL divzero_latency: got %0d expected 1", lat);
    end
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL divzero_result: got x3=%0d ab=%0d rem=%0d dz=%0d expected x3=%0d ab=%0d rem=%0d dz=%0d",
               obs.x3, obs.ab, obs.rem, obs.dz, e.x3, e.ab, e.rem, e.dz);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [N-1:0] f, d, c;
    res_t         e;
    int           lat;
    int           exp_lat;
    for (int i = 0; i < 24; i++) begin
      f = N'($urandom);
      c = N'($urandom);
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = 10'd1;
        2:       d = N'($urandom_range(2, 15));
        default: d = N'($urandom_range(1, MASK));
      endcase
      e       = model(f, d, c);
      exp_lat = (d == '0) ? 1 : N + 1;
      run_op(f, d, c, lat);
      tests_run++;
      if (lat !== exp_lat || obs !== e) begin
        tests_failed++;
        $display("FAIL random_%0d (F=%0d D=%0d C=%0d): got lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d expected lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d",
                 i, f, d, c, lat, obs.x3, obs.ab, obs.rem, obs.dz, exp_lat, e.x3, e.ab, e.rem, e.dz);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] f2, d2, c2;
    res_t         e1, e2;
    int           lat;
    f2 = N'($urandom); d2 = N'($urandom_range(1, MASK)); c2 = N'($urandom);
    e1 = model(10'd156, 10'd6, 10'd20);
    e2 = model(f2, d2, c2);
    run_op(10'd156, 10'd6, 10'd20, lat);
    F = f2; D = d2; C = c2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, e1}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got out_valid=%0b in_ready=%0b x3=%0d ab=%0d dz=%0d expected 1 0 x3=%0d ab=%0d dz=%0d",
                 i, out_valid, in_ready, obs.x3, obs.ab, obs.dz, e1.x3, e1.ab, e1.dz);
      end
    end
    handshake();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_release: got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 4 * N) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (lat !== N + 1 || obs !== e2) begin
      tests_failed++;
      $display("FAIL bp_second_op: got lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d expected lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d",
               lat, obs.x3, obs.ab, obs.rem, obs.dz, N + 1, e2.x3, e2.ab, e2.rem, e2.dz);
    end
    handshake();
  endtask

  task automatic test_reset_mid_op();
    res_t e;
    int   lat;
    bit   spurious;
    e = model(10'd156, 10'd6, 10'd20);
    F = 10'd200; D = 10'd9; C = 10'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, obs} !== {1'b0, 1'b1, {(3*N+1){1'b0}}}) begin
      tests_failed++;
      $display("FAIL midreset_clear: got out_valid=%0b in_ready=%0b res=%h expected 0 1 0",
               out_valid, in_ready, obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) spurious = 1'b1;
    end
    tests_run++;
    if (spurious !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_abort: got a result or busy state after reset, expected idle");
    end
    run_op(10'd156, 10'd6, 10'd20, lat);
    tests_run++;
    if (lat !== N + 1 || obs !== e) begin
      tests_failed++;
      $display("FAIL midreset_next_op: got lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d expected lat=%0d x3=%0d ab=%0d rem=%0d dz=%0d",
               lat, obs.x3, obs.ab, obs.rem, obs.dz, N + 1, e.x3, e.ab, e.rem, e.dz);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] fs [3];
    logic [N-1:0] ds [3];
    logic [N-1:0] cs [3];
    res_t         e;
    int           sent, got, cyc, last;
    logic         cap;
    for (int i = 0; i < 3; i++) begin
      fs[i] = N'($urandom);
      ds[i] = N'($urandom_range(1, MASK));
      cs[i] = N'($urandom);
    end
    sent = 0; got = 0; cyc = 0; last = 0;
    F = fs[0]; D = ds[0]; C = cs[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      cap = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (cap) begin
        sent++;
        if (sent < 3) begin
          F = fs[sent]; D = ds[sent]; C = cs[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        e = model(fs[got], ds[got], cs[got]);
        tests_run++;
        if (obs !== e) begin
          tests_failed++;
          $display("FAIL b2b_result_%0d: got x3=%0d ab=%0d rem=%0d dz=%0d expected x3=%0d ab=%0d rem=%0d dz=%0d",
                   got, obs.x3, obs.ab, obs.rem, obs.dz, e.x3, e.ab, e.rem, e.dz);
        end
        if (got > 0) begin
          tests_run++;
          if (cyc - last !== N + 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing_%0d: got %0d cycles expected %0d", got, cyc - last, N + 2);
          end
        end
        last = cyc;
        got++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (got !== 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d results expected 3", got);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_remainder_wrap();
    test_div_zero();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
